// File: rtl/cpu_defs_pkg.sv
// ============================================================================
// cpu_defs_pkg : opcodes, ALU codes, state codes and select encodings
// Revision     : 1.0
// ============================================================================
`default_nettype none

package cpu_defs_pkg;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_ADDIU = 6'b000010;
   localparam logic [5:0] OP_AND   = 6'b010000;
   localparam logic [5:0] OP_ANDI  = 6'b010001;
   localparam logic [5:0] OP_ORI   = 6'b010010;
   localparam logic [5:0] OP_XORI  = 6'b010011;
   localparam logic [5:0] OP_SLL   = 6'b011000;
   localparam logic [5:0] OP_SLTI  = 6'b100110;
   localparam logic [5:0] OP_SLT   = 6'b100111;
   localparam logic [5:0] OP_SW    = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b110001;
   localparam logic [5:0] OP_BEQ   = 6'b110100;
   localparam logic [5:0] OP_BNE   = 6'b110101;
   localparam logic [5:0] OP_BLTZ  = 6'b110110;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_JR    = 6'b111001;
   localparam logic [5:0] OP_JAL   = 6'b111010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_SLL = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b110;
   localparam logic [2:0] ALU_XOR = 3'b111;

   typedef enum logic [2:0] {
      S_IF     = 3'b000,
      S_ID     = 3'b001,
      S_EXE_LS = 3'b010,
      S_MEM    = 3'b011,
      S_WB_LD  = 3'b100,
      S_EXE_BR = 3'b101,
      S_EXE_AL = 3'b110,
      S_WB_AL  = 3'b111
   } state_t;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'b00,
      PC_BRANCH = 2'b01,
      PC_RS     = 2'b10,
      PC_JUMP   = 2'b11
   } pc_src_t;

   typedef enum logic [1:0] {
      REG_31 = 2'b00,
      REG_RT = 2'b01,
      REG_RD = 2'b10
   } reg_dst_t;

   function automatic logic is_rtype(input logic [5:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
             (op == OP_SLT) || (op == OP_SLL);
   endfunction

   function automatic logic is_itype_alu(input logic [5:0] op);
      return (op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_ORI) ||
             (op == OP_XORI)  || (op == OP_SLTI);
   endfunction

   function automatic logic [2:0] alu_code(input logic [5:0] op);
      case (op)
         OP_SUB:          return ALU_SUB;
         OP_AND, OP_ANDI: return ALU_AND;
         OP_ORI:          return ALU_OR;
         OP_XORI:         return ALU_XOR;
         OP_SLT, OP_SLTI: return ALU_SLT;
         OP_SLL:          return ALU_SLL;
         default:         return ALU_ADD;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/control_output_decoder.sv
// ============================================================================
// control_output_decoder : (state, op, zero, sign) -> datapath control map
// Revision               : 1.0
// ============================================================================
`default_nettype none

module control_output_decoder
   import cpu_defs_pkg::*;
(
   input  state_t     state_q,
   input  logic       halted,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       sign,
   output logic       PCWre,
   output logic       IRWre,
   output logic       InsMemRW,
   output logic       RegWre,
   output logic [1:0] RegDst,
   output logic       WrRegDSrc,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic       ExtSel,
   output logic [2:0] ALUOp,
   output logic       mRD,
   output logic       mWR,
   output logic       DBDataSrc,
   output logic [1:0] PCSrc
);

   logic w_taken;

   always_comb begin
      w_taken = 1'b0;
      case (op)
         OP_BEQ:  w_taken = zero;
         OP_BNE:  w_taken = ~zero;
         OP_BLTZ: w_taken = sign;
         default: w_taken = 1'b0;
      endcase
   end

   always_comb begin
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      InsMemRW  = 1'b0;
      RegWre    = 1'b0;
      RegDst    = REG_31;
      WrRegDSrc = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ExtSel    = 1'b0;
      ALUOp     = ALU_ADD;
      mRD       = 1'b0;
      mWR       = 1'b0;
      DBDataSrc = 1'b0;
      PCSrc     = PC_SEQ;

      if (!halted) begin
         case (state_q)
            S_IF: begin
               InsMemRW = 1'b1;
               IRWre    = 1'b1;
            end
            S_ID: begin
               case (op)
                  OP_J: begin
                     PCWre = 1'b1;
                     PCSrc = PC_JUMP;
                  end
                  OP_JAL: begin
                     PCWre     = 1'b1;
                     PCSrc     = PC_JUMP;
                     RegWre    = 1'b1;
                     RegDst    = REG_31;
                     WrRegDSrc = 1'b0;
                  end
                  OP_JR: begin
                     PCWre = 1'b1;
                     PCSrc = PC_RS;
                  end
                  OP_HALT, OP_BEQ, OP_BNE, OP_BLTZ, OP_LW, OP_SW: ;
                  default: begin
                     // Unknown opcodes retire as a NOP
                     if (!is_rtype(op) && !is_itype_alu(op)) begin
                        PCWre = 1'b1;
                        PCSrc = PC_SEQ;
                     end
                  end
               endcase
            end
            S_EXE_AL, S_WB_AL: begin
               // ALU result is not registered, so operand selects hold through WB
               ALUOp   = alu_code(op);
               ALUSrcA = (op == OP_SLL);
               ALUSrcB = ~is_rtype(op);
               ExtSel  = ~((op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI));
               if (state_q == S_WB_AL) begin
                  RegWre    = 1'b1;
                  DBDataSrc = 1'b0;
                  WrRegDSrc = 1'b1;
                  RegDst    = is_rtype(op) ? REG_RD : REG_RT;
                  PCWre     = 1'b1;
                  PCSrc     = PC_SEQ;
               end
            end
            S_EXE_BR: begin
               ALUOp = ALU_SUB;
               PCWre = 1'b1;
               PCSrc = w_taken ? PC_BRANCH : PC_SEQ;
            end
            S_EXE_LS, S_MEM, S_WB_LD: begin
               ALUOp   = ALU_ADD;
               ALUSrcB = 1'b1;
               ExtSel  = 1'b1;
               if (state_q == S_MEM) begin
                  if (op == OP_SW) begin
                     mWR   = 1'b1;
                     PCWre = 1'b1;
                     PCSrc = PC_SEQ;
                  end else begin
                     mRD = 1'b1;
                  end
               end else if (state_q == S_WB_LD) begin
                  RegWre    = 1'b1;
                  DBDataSrc = 1'b1;
                  RegDst    = REG_RT;
                  WrRegDSrc = 1'b1;
                  PCWre     = 1'b1;
                  PCSrc     = PC_SEQ;
               end
            end
            default: ;
         endcase
      end

      // Reset cycle must never commit architectural state
      if (rst) begin
         PCWre  = 1'b0;
         IRWre  = 1'b0;
         RegWre = 1'b0;
         mWR    = 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ============================================================================
// multicycle_control_unit : IF/ID/EXE/MEM/WB sequencer for the shared datapath
// Revision                : 1.0
// ============================================================================
`default_nettype none

module multicycle_control_unit
   import cpu_defs_pkg::*;
#(
   parameter int STATE_W = 3,
   parameter int OP_W    = 6
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic [OP_W-1:0]    op,
   input  logic               zero,
   input  logic               sign,
   output logic               PCWre,
   output logic               IRWre,
   output logic               InsMemRW,
   output logic               RegWre,
   output logic [1:0]         RegDst,
   output logic               WrRegDSrc,
   output logic               ALUSrcA,
   output logic               ALUSrcB,
   output logic               ExtSel,
   output logic [2:0]         ALUOp,
   output logic               mRD,
   output logic               mWR,
   output logic               DBDataSrc,
   output logic [1:0]         PCSrc,
   output logic [STATE_W-1:0] state
);

   state_t r_state, w_next_state;
   logic   r_halted, w_next_halted;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state  <= S_IF;
         r_halted <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_halted <= w_next_halted;
      end
   end

   always_comb begin
      w_next_state  = r_state;
      w_next_halted = r_halted;
      if (!r_halted) begin
         case (r_state)
            S_IF: w_next_state = S_ID;
            S_ID: begin
               case (op)
                  OP_HALT: begin
                     // Halt parks on the sIF code with the flag set
                     w_next_state  = S_IF;
                     w_next_halted = 1'b1;
                  end
                  OP_BEQ, OP_BNE, OP_BLTZ: w_next_state = S_EXE_BR;
                  OP_LW, OP_SW:            w_next_state = S_EXE_LS;
                  default: w_next_state = (is_rtype(op) || is_itype_alu(op)) ? S_EXE_AL : S_IF;
               endcase
            end
            S_EXE_AL: w_next_state = S_WB_AL;
            S_EXE_BR: w_next_state = S_IF;
            S_EXE_LS: w_next_state = S_MEM;
            S_MEM:    w_next_state = (op == OP_LW) ? S_WB_LD : S_IF;
            S_WB_AL:  w_next_state = S_IF;
            S_WB_LD:  w_next_state = S_IF;
            default:  w_next_state = S_IF;
         endcase
      end
   end

   assign state = STATE_W'(r_state);

   control_output_decoder u_decoder (
      .state_q   (r_state),
      .halted    (r_halted),
      .rst       (Reset),
      .op        (op),
      .zero      (zero),
      .sign      (sign),
      .PCWre     (PCWre),
      .IRWre     (IRWre),
      .InsMemRW  (InsMemRW),
      .RegWre    (RegWre),
      .RegDst    (RegDst),
      .WrRegDSrc (WrRegDSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ExtSel    (ExtSel),
      .ALUOp     (ALUOp),
      .mRD       (mRD),
      .mWR       (mWR),
      .DBDataSrc (DBDataSrc),
      .PCSrc     (PCSrc)
   );

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
// tb_multicycle_control_unit : directed checks of the multicycle controller
// Revision                   : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control_unit;

   localparam logic [5:0] T_ADD  = 6'b000000;
   localparam logic [5:0] T_ANDI = 6'b010001;
   localparam logic [5:0] T_SLL  = 6'b011000;
   localparam logic [5:0] T_SW   = 6'b110000;
   localparam logic [5:0] T_LW   = 6'b110001;
   localparam logic [5:0] T_BEQ  = 6'b110100;
   localparam logic [5:0] T_BNE  = 6'b110101;
   localparam logic [5:0] T_BLTZ = 6'b110110;
   localparam logic [5:0] T_JR   = 6'b111001;
   localparam logic [5:0] T_JAL  = 6'b111010;
   localparam logic [5:0] T_HALT = 6'b111111;
   localparam logic [5:0] T_UNDF = 6'b111110;

   logic       clk;
   logic       rst;
   logic [5:0] op;
   logic       zero, sign;
   logic       PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc;
   logic       ALUSrcA, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc;
   logic [1:0] RegDst, PCSrc;
   logic [2:0] ALUOp, state;

   int errors = 0;
   int checks = 0;

   multicycle_control_unit #(.STATE_W(3), .OP_W(6)) dut (
      .CLK       (clk),
      .Reset     (rst),
      .op        (op),
      .zero      (zero),
      .sign      (sign),
      .PCWre     (PCWre),
      .IRWre     (IRWre),
      .InsMemRW  (InsMemRW),
      .RegWre    (RegWre),
      .RegDst    (RegDst),
      .WrRegDSrc (WrRegDSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ExtSel    (ExtSel),
      .ALUOp     (ALUOp),
      .mRD       (mRD),
      .mWR       (mWR),
      .DBDataSrc (DBDataSrc),
      .PCSrc     (PCSrc),
      .state     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst  = 1'b1;
      op   = T_ADD;
      zero = 1'b0;
      sign = 1'b0;
      tick();
      tick();
      check("rst_state", 8'(state), 8'h0);
      check("rst_irwre", 8'(IRWre), 8'h0);
      check("rst_pcwre", 8'(PCWre), 8'h0);
      rst = 1'b0;
      #1;

      // add: 000 001 110 111 000
      check("if_irwre", 8'(IRWre), 8'h1);
      check("if_imem", 8'(InsMemRW), 8'h1);
      check("if_pcsrc", 8'(PCSrc), 8'h0);
      check("if_regwre", 8'(RegWre), 8'h0);
      tick();
      check("add_id_state", 8'(state), 8'h1);
      check("add_id_pcwre", 8'(PCWre), 8'h0);
      check("add_id_irwre", 8'(IRWre), 8'h0);
      tick();
      check("add_exe_state", 8'(state), 8'h6);
      check("add_exe_pcwre", 8'(PCWre), 8'h0);
      check("add_exe_aluop", 8'(ALUOp), 8'h0);
      check("add_exe_srcb", 8'(ALUSrcB), 8'h0);
      tick();
      check("add_wb_state", 8'(state), 8'h7);
      check("add_wb_regwre", 8'(RegWre), 8'h1);
      check("add_wb_regdst", 8'(RegDst), 8'h2);
      check("add_wb_wrsrc", 8'(WrRegDSrc), 8'h1);
      check("add_wb_dbsrc", 8'(DBDataSrc), 8'h0);
      check("add_wb_pcwre", 8'(PCWre), 8'h1);
      tick();
      check("add_done_state", 8'(state), 8'h0);

      // lw: 5 cycles
      op = T_LW;
      tick();
      tick();
      check("lw_exe_state", 8'(state), 8'h2);
      check("lw_exe_srcb", 8'(ALUSrcB), 8'h1);
      check("lw_exe_ext", 8'(ExtSel), 8'h1);
      check("lw_exe_pcwre", 8'(PCWre), 8'h0);
      tick();
      check("lw_mem_state", 8'(state), 8'h3);
      check("lw_mem_mrd", 8'(mRD), 8'h1);
      check("lw_mem_mwr", 8'(mWR), 8'h0);
      check("lw_mem_pcwre", 8'(PCWre), 8'h0);
      tick();
      check("lw_wb_state", 8'(state), 8'h4);
      check("lw_wb_regwre", 8'(RegWre), 8'h1);
      check("lw_wb_dbsrc", 8'(DBDataSrc), 8'h1);
      check("lw_wb_regdst", 8'(RegDst), 8'h1);
      check("lw_wb_pcwre", 8'(PCWre), 8'h1);
      tick();
      check("lw_done_state", 8'(state), 8'h0);

      // sw: 4 cycles
      op = T_SW;
      tick();
      check("sw_id_regwre", 8'(RegWre), 8'h0);
      tick();
      check("sw_exe_regwre", 8'(RegWre), 8'h0);
      tick();
      check("sw_mem_state", 8'(state), 8'h3);
      check("sw_mem_mwr", 8'(mWR), 8'h1);
      check("sw_mem_regwre", 8'(RegWre), 8'h0);
      check("sw_mem_pcwre", 8'(PCWre), 8'h1);
      tick();
      check("sw_done_state", 8'(state), 8'h0);

      // branches
      op = T_BEQ; zero = 1'b1;
      tick(); tick();
      check("beq_t_state", 8'(state), 8'h5);
      check("beq_t_pcsrc", 8'(PCSrc), 8'h1);
      check("beq_t_pcwre", 8'(PCWre), 8'h1);
      check("beq_t_aluop", 8'(ALUOp), 8'h1);
      tick();
      check("beq_done_state", 8'(state), 8'h0);
      zero = 1'b0;
      tick(); tick();
      check("beq_n_pcsrc", 8'(PCSrc), 8'h0);
      check("beq_n_pcwre", 8'(PCWre), 8'h1);
      tick();
      op = T_BNE;
      tick(); tick();
      check("bne_t_pcsrc", 8'(PCSrc), 8'h1);
      tick();
      op = T_BLTZ; sign = 1'b1;
      tick(); tick();
      check("bltz_t_pcsrc", 8'(PCSrc), 8'h1);
      tick();
      sign = 1'b0; zero = 1'b1;
      tick(); tick();
      check("bltz_n_pcsrc", 8'(PCSrc), 8'h0);
      tick();
      zero = 1'b0;

      // jal / jr
      op = T_JAL;
      tick();
      check("jal_state", 8'(state), 8'h1);
      check("jal_pcwre", 8'(PCWre), 8'h1);
      check("jal_pcsrc", 8'(PCSrc), 8'h3);
      check("jal_regwre", 8'(RegWre), 8'h1);
      check("jal_regdst", 8'(RegDst), 8'h0);
      check("jal_wrsrc", 8'(WrRegDSrc), 8'h0);
      tick();
      check("jal_done_state", 8'(state), 8'h0);
      op = T_JR;
      tick();
      check("jr_pcsrc", 8'(PCSrc), 8'h2);
      check("jr_pcwre", 8'(PCWre), 8'h1);
      check("jr_regwre", 8'(RegWre), 8'h0);
      tick();

      // I-type and shift operand selects
      op = T_ANDI;
      tick(); tick();
      check("andi_ext", 8'(ExtSel), 8'h0);
      check("andi_srcb", 8'(ALUSrcB), 8'h1);
      tick();
      check("andi_regdst", 8'(RegDst), 8'h1);
      tick();
      op = T_SLL;
      tick(); tick();
      check("sll_srca", 8'(ALUSrcA), 8'h1);
      tick(); tick();

      // halt
      op = T_HALT;
      tick();
      check("halt_id_pcwre", 8'(PCWre), 8'h0);
      for (int i = 0; i < 12; i++) begin
         tick();
         check("halt_state", 8'(state), 8'h0);
         check("halt_pcwre", 8'(PCWre), 8'h0);
         check("halt_irwre", 8'(IRWre), 8'h0);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      op  = T_ADD;
      #1;
      check("unhalt_state", 8'(state), 8'h0);
      check("unhalt_irwre", 8'(IRWre), 8'h1);
      tick();
      check("unhalt_id", 8'(state), 8'h1);
      tick(); tick(); tick();

      // reset during sMEM of sw
      op = T_SW;
      tick(); tick(); tick();
      check("swr_pre_mwr", 8'(mWR), 8'h1);
      rst = 1'b1;
      #1;
      check("swr_state", 8'(state), 8'h3);
      check("swr_mwr", 8'(mWR), 8'h0);
      check("swr_pcwre", 8'(PCWre), 8'h0);
      tick();
      rst = 1'b0;
      #1;
      check("swr_after_state", 8'(state), 8'h0);
      check("swr_after_irwre", 8'(IRWre), 8'h1);

      // undefined opcode acts as a 2-cycle NOP
      op = T_UNDF;
      tick();
      check("undf_state", 8'(state), 8'h1);
      check("undf_pcwre", 8'(PCWre), 8'h1);
      check("undf_pcsrc", 8'(PCSrc), 8'h0);
      check("undf_regwre", 8'(RegWre), 8'h0);
      tick();
      check("undf_done_state", 8'(state), 8'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
